// File: rtl/instruction_fetch.sv
// instruction_fetch: PC holder and single-word fetch engine with request/ready memory handshake,
// redirect kill handling and a delivered-instruction counter.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr_out,
    output logic        ir_write,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_out,
    output logic        fetch_busy,
    output logic        misaligned_fault,
    output logic [31:0] fetch_count
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      r_state, w_state_n;
    logic [31:0] r_pc, r_imem_addr, r_instr, r_instr_pc, r_count, r_redir_pc;
    logic        r_imem_req, r_ir_write, r_fault, r_kill;
    logic [31:0] w_pc_n, w_addr_n, w_instr_n, w_ipc_n, w_count_n, w_redir_n, w_fetch_addr;
    logic        w_req_n, w_ir_n, w_fault_n, w_kill_n;

    assign w_fetch_addr = redirect_valid ? redirect_pc : r_pc;

    always_comb begin
        w_state_n = r_state;
        w_pc_n    = r_pc;
        w_addr_n  = r_imem_addr;
        w_req_n   = r_imem_req;
        w_instr_n = r_instr;
        w_ipc_n   = r_instr_pc;
        w_ir_n    = 1'b0;
        w_fault_n = 1'b0;
        w_count_n = r_count;
        w_kill_n  = r_kill;
        w_redir_n = r_redir_pc;
        case (r_state)
            S_IDLE: begin
                if (fetch_en) begin
                    w_pc_n = w_fetch_addr;
                    if (w_fetch_addr[1:0] == 2'b00) begin
                        w_addr_n  = w_fetch_addr;
                        w_req_n   = 1'b1;
                        w_state_n = S_WAIT;
                    end else begin
                        w_fault_n = 1'b1;
                    end
                end else if (redirect_valid) begin
                    w_pc_n = redirect_pc;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    w_kill_n  = 1'b1;
                    w_redir_n = redirect_pc;
                end
                // A redirect arriving in the ready cycle itself still kills the fetch.
                if (imem_ready) begin
                    w_req_n   = 1'b0;
                    w_kill_n  = 1'b0;
                    w_state_n = S_IDLE;
                    if (r_kill || redirect_valid) begin
                        w_pc_n = redirect_valid ? redirect_pc : r_redir_pc;
                    end else begin
                        w_instr_n = imem_rdata;
                        w_ipc_n   = r_imem_addr;
                        w_pc_n    = r_imem_addr + 32'd4;
                        w_ir_n    = 1'b1;
                        w_count_n = r_count + 32'd1;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_imem_addr <= RESET_PC;
            r_imem_req  <= 1'b0;
            r_instr     <= 32'd0;
            r_instr_pc  <= 32'd0;
            r_ir_write  <= 1'b0;
            r_fault     <= 1'b0;
            r_count     <= 32'd0;
            r_kill      <= 1'b0;
            r_redir_pc  <= 32'd0;
        end else begin
            r_state     <= w_state_n;
            r_pc        <= w_pc_n;
            r_imem_addr <= w_addr_n;
            r_imem_req  <= w_req_n;
            r_instr     <= w_instr_n;
            r_instr_pc  <= w_ipc_n;
            r_ir_write  <= w_ir_n;
            r_fault     <= w_fault_n;
            r_count     <= w_count_n;
            r_kill      <= w_kill_n;
            r_redir_pc  <= w_redir_n;
        end
    end

    assign imem_req         = r_imem_req;
    assign imem_addr        = r_imem_addr;
    assign instr_out        = r_instr;
    assign ir_write         = r_ir_write;
    assign instr_pc         = r_instr_pc;
    assign pc_out           = r_pc;
    assign fetch_busy       = (r_state == S_WAIT);
    assign misaligned_fault = r_fault;
    assign fetch_count      = r_count;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scenario tasks drive the fetch stage; expected deliveries are queued
// when memory data is offered and popped when ir_write pulses.
module tb_instruction_fetch;
    logic        clk = 1'b0;
    logic        reset, fetch_en, redirect_valid, imem_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, ir_write, fetch_busy, misaligned_fault;
    logic [31:0] imem_addr, instr_out, instr_pc, pc_out, fetch_count;
    logic [63:0] sb[$];
    int          vectors = 0;
    int          errors = 0;

    instruction_fetch #(.RESET_PC(32'h100)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .instr_out(instr_out),
        .ir_write(ir_write), .instr_pc(instr_pc), .pc_out(pc_out), .fetch_busy(fetch_busy),
        .misaligned_fault(misaligned_fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] data, input logic expect_deliver);
        imem_ready = 1'b1;
        imem_rdata = data;
        if (expect_deliver) sb.push_back({data, imem_addr});
    endtask

    task automatic check_delivery(input string name);
        logic [63:0] e;
        vectors++;
        if (ir_write !== 1'b1) begin
            errors++; $display("FAIL %s ir_write: got %b want 1", name, ir_write);
        end else if (sb.size() == 0) begin
            errors++; $display("FAIL %s: ir_write with empty scoreboard", name);
        end else begin
            e = sb.pop_front();
            if (instr_out !== e[63:32] || instr_pc !== e[31:0]) begin
                errors++; $display("FAIL %s data: got %h@%h want %h@%h", name, instr_out, instr_pc, e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        imem_ready = 1'b0; imem_rdata = 32'd0;
        tick(); tick();
        reset = 1'b0;
        vectors++; if (pc_out !== 32'h100) begin errors++; $display("FAIL reset_pc: got %h want %h", pc_out, 32'h100); end
        vectors++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, 32'h100); end
        vectors++; if ({imem_req, ir_write, fetch_busy, misaligned_fault} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {imem_req, ir_write, fetch_busy, misaligned_fault}); end
        vectors++; if (instr_out !== 32'd0 || instr_pc !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h/%h want 0/0", instr_out, instr_pc); end
        vectors++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    endtask

    task automatic test_zero_wait();
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || fetch_busy !== 1'b1) begin errors++; $display("FAIL zw_issue: got req=%b addr=%h busy=%b want 1/100/1", imem_req, imem_addr, fetch_busy); end
        offer(32'h003100B3, 1'b1);
        tick();
        imem_ready = 1'b0;
        check_delivery("zw");
        vectors++; if (pc_out !== 32'h104) begin errors++; $display("FAIL zw_pc: got %h want %h", pc_out, 32'h104); end
        vectors++; if (fetch_count !== 32'd1) begin errors++; $display("FAIL zw_count: got %0d want 1", fetch_count); end
        tick();
        vectors++; if (ir_write !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL zw_after: got ir=%b req=%b want 0/0", ir_write, imem_req); end
    endtask

    task automatic test_wait_states();
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin errors++; $display("FAIL ws_issue: got req=%b addr=%h want 1/104", imem_req, imem_addr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            fetch_en = (i == 0);
            vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h104 || ir_write !== 1'b0) begin errors++; $display("FAIL ws_hold%0d: got req=%b addr=%h ir=%b want 1/104/0", i, imem_req, imem_addr, ir_write); end
        end
        fetch_en = 1'b0;
        offer(32'h02A28213, 1'b1);
        tick();
        imem_ready = 1'b0;
        check_delivery("ws");
        tick();
        vectors++; if (ir_write !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL ws_single: got ir=%b req=%b want 0/0", ir_write, imem_req); end
        vectors++; if (fetch_count !== 32'd2 || pc_out !== 32'h108) begin errors++; $display("FAIL ws_state: got cnt=%0d pc=%h want 2/108", fetch_count, pc_out); end
    endtask

    task automatic test_redirect();
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        offer(32'h0063A423, 1'b0);
        tick();
        imem_ready = 1'b0;
        vectors++; if (ir_write !== 1'b0 || instr_out !== 32'h02A28213) begin errors++; $display("FAIL rd_kill: got ir=%b instr=%h want 0/02a28213", ir_write, instr_out); end
        vectors++; if (pc_out !== 32'h200 || fetch_count !== 32'd2 || imem_req !== 1'b0) begin errors++; $display("FAIL rd_state: got pc=%h cnt=%0d req=%b want 200/2/0", pc_out, fetch_count, imem_req); end
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        vectors++; if (imem_addr !== 32'h200 || imem_req !== 1'b1) begin errors++; $display("FAIL rd_next: got addr=%h req=%b want 200/1", imem_addr, imem_req); end
        offer(32'h00000013, 1'b1);
        tick();
        imem_ready = 1'b0;
        check_delivery("rd_next");
        // Redirect arriving in the very cycle memory is ready must still win.
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        offer(32'hDEADBEEF, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        imem_ready = 1'b0; redirect_valid = 1'b0;
        vectors++; if (ir_write !== 1'b0 || pc_out !== 32'h300 || fetch_count !== 32'd3) begin errors++; $display("FAIL rd_same: got ir=%b pc=%h cnt=%0d want 0/300/3", ir_write, pc_out, fetch_count); end
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1; redirect_pc = 32'h202; fetch_en = 1'b1;
        tick();
        redirect_valid = 1'b0; fetch_en = 1'b0;
        vectors++; if (misaligned_fault !== 1'b1 || imem_req !== 1'b0 || pc_out !== 32'h202) begin errors++; $display("FAIL mis: got fault=%b req=%b pc=%h want 1/0/202", misaligned_fault, imem_req, pc_out); end
        tick();
        vectors++; if (misaligned_fault !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL mis_pulse: got fault=%b req=%b want 0/0", misaligned_fault, imem_req); end
    endtask

    task automatic test_reset_in_wait();
        redirect_valid = 1'b1; redirect_pc = 32'h400; fetch_en = 1'b1;
        tick();
        redirect_valid = 1'b0; fetch_en = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if (imem_req !== 1'b0 || fetch_busy !== 1'b0) begin errors++; $display("FAIL rw_drop: got req=%b busy=%b want 0/0", imem_req, fetch_busy); end
        offer(32'h11111111, 1'b0);
        tick();
        imem_ready = 1'b0;
        vectors++; if (ir_write !== 1'b0 || instr_out !== 32'd0 || fetch_count !== 32'd0 || pc_out !== 32'h100) begin errors++; $display("FAIL rw_state: got ir=%b instr=%h cnt=%0d pc=%h want 0/0/0/100", ir_write, instr_out, fetch_count, pc_out); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; fetch_en = 1'b1;
        tick();
        redirect_valid = 1'b0; fetch_en = 1'b0;
        offer(32'h00A00093, 1'b1);
        tick();
        imem_ready = 1'b0;
        check_delivery("wrap");
        vectors++; if (pc_out !== 32'd0) begin errors++; $display("FAIL wrap_pc: got %h want 0", pc_out); end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        fetch_en = 1'b1;
        imem_ready = 1'b1; imem_rdata = 32'h00000013;
        for (int i = 0; i < 4; i++) begin
            if (imem_req) sb.push_back({imem_rdata, imem_addr});
            tick();
            if (ir_write) begin got++; check_delivery("b2b"); end
        end
        fetch_en = 1'b0; imem_ready = 1'b0;
        vectors++; if (got != 2 || fetch_count !== 32'd3 || pc_out !== 32'h8) begin errors++; $display("FAIL b2b_rate: got n=%0d cnt=%0d pc=%h want 2/3/8", got, fetch_count, pc_out); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_redirect();
        test_misaligned();
        test_reset_in_wait();
        test_wrap();
        test_back_to_back();
        vectors++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the 32-bit multicycle CPU.
- Holds the program counter and issues single-word reads to instruction memory over a request/ready handshake.
- Delivers each fetched word to the Instruction_Register through `instr_out`/`ir_write`, which drive IR `instruction_in`/`ir_write` directly.
- Accepts branch/jump redirects from the execute stage.
- Counts delivered instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk, in, 1, system clock; all state updates on rising edge.
- reset, in, 1, synchronous, active-high; one clock, reset is synchronous and active-high.
- fetch_en, in, 1, control unit requests the next fetch; sampled only in IDLE.
- redirect_valid, in, 1, load redirect_pc as the next fetch address.
- redirect_pc, in, 32, branch/jump target.
- imem_req, out, 1, memory read request (registered).
- imem_addr, out, 32, word address of the request (registered); stable while imem_req=1.
- imem_rdata, in, 32, memory read data; valid when imem_ready=1.
- imem_ready, in, 1, memory completes the request this cycle.
- instr_out, out, 32, last delivered instruction; connects to IR instruction_in.
- ir_write, out, 1, one-cycle pulse when instr_out holds a new instruction.
- instr_pc, out, 32, address of the instruction in instr_out.
- pc_out, out, 32, current PC (next fetch address).
- fetch_busy, out, 1, high in WAIT state.
- misaligned_fault, out, 1, one-cycle pulse when a fetch is attempted at pc[1:0]!=0.
- fetch_count, out, 32, number of delivered instructions; wraps modulo 2^32.

## Operation
- States are IDLE and WAIT; reset enters IDLE.
- IDLE, fetch address selection: fetch address = redirect_pc if redirect_valid, else pc.
- IDLE, redirect only: redirect_valid with fetch_en=0 loads pc<=redirect_pc and stays in IDLE.
- IDLE, fetch_en=1 with fetch address aligned:
  - imem_addr<=fetch address, pc<=fetch address, imem_req<=1.
  - Go to WAIT.
- IDLE, fetch_en=1 with fetch address misaligned:
  - No request is issued; misaligned_fault<=1 for one cycle.
  - pc<=fetch address; stay in IDLE.
- WAIT behaviour:
  - imem_req=1 and imem_addr is held.
  - redirect_valid=1 (any cycle in WAIT, including the ready cycle) sets kill and latches redirect_pc; a later redirect overwrites the earlier one.
- WAIT, imem_ready=1 and not killed:
  - instr_out<=imem_rdata, instr_pc<=imem_addr, pc<=imem_addr+4, ir_write<=1.
  - fetch_count<=fetch_count+1; imem_req<=0; go to IDLE.
- WAIT, imem_ready=1 and killed:
  - Data is discarded; ir_write stays 0 and instr_out is unchanged.
  - pc<=latched redirect; kill cleared; imem_req<=0; go to IDLE.
- fetch_en in WAIT is ignored; it is not queued.
- imem_ready outside WAIT is ignored.
- ir_write is cleared every cycle it is not set by a completing fetch.
- misaligned_fault is cleared every cycle it is not set.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).

## Timing
- Reset values:
  - pc_out=RESET_PC, imem_addr=RESET_PC.
  - imem_req=0, instr_out=0, instr_pc=0, ir_write=0.
  - fetch_busy=0, misaligned_fault=0, fetch_count=0; kill=0.
- Latency: fetch_en sampled at edge N -> imem_req=1 after N. Ready in the first WAIT cycle (sampled at edge N+1) -> ir_write=1, instr_out valid after N+1; minimum 2 cycles from fetch_en to ir_write.
- Back-to-back fetching: fetch_en held high gives one delivery every 2 cycles with zero-wait memory.
- Wait states: each extra cycle of imem_ready=0 adds one cycle of latency.
- Reset mid-WAIT: imem_req drops after the reset edge; any later imem_ready is ignored; nothing is delivered.
- Redirect and imem_ready in the same WAIT cycle: redirect wins, data is dropped, pc=redirect_pc.

## Test plan
- Reset with RESET_PC=32'h100 -> pc_out=32'h100, imem_req=0, instr_out=0, fetch_count=0.
- fetch_en with zero-wait memory returning 32'h003100B3 -> imem_addr=32'h100 for one cycle; next cycle ir_write=1, instr_out=32'h003100B3, instr_pc=32'h100, pc_out=32'h104, fetch_count=1.
- Memory with 3 wait states returning 32'h02A28213; pulse fetch_en again during WAIT -> imem_addr held for 4 cycles; exactly one ir_write pulse; fetch_count increments by 1.
- Redirect to 32'h200 in the second WAIT cycle, then ready with 32'h0063A423 -> no ir_write, instr_out unchanged, pc_out=32'h200; next fetch issues imem_addr=32'h200.
- redirect_valid with redirect_pc=32'h202 and fetch_en together -> misaligned_fault pulses 1 cycle, imem_req stays 0, pc_out=32'h202.
- Assert reset in WAIT, then raise imem_ready -> no ir_write; outputs return to reset values; PC wraps 32'hFFFF_FFFC -> 0 after a fetch there.
